// File: rtl/acap_mailbox_ctrl.sv
// Mailbox sequencer for the shared interface BRAM port: polls the host start word,
// launches the AddToACAP core, lends it the port while it runs, then posts a done/error marker.
module acap_mailbox_ctrl #(
  parameter logic [31:0] START_ADDR    = 32'h1004,
  parameter logic [31:0] DONE_ADDR     = 32'h1789,
  parameter logic [31:0] START_MAGIC   = 32'hDEADBEEF,
  parameter logic [31:0] DONE_MAGIC    = 32'hD01ECAFE,
  parameter logic [31:0] ERR_MAGIC     = 32'hBADC0DE5,
  parameter logic [31:0] CLEAR_WORD    = 32'h0,
  parameter int unsigned POLL_INTERVAL = 16,
  parameter int unsigned TIMEOUT       = 200000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        bram_en,
  output logic [3:0]  bram_we,
  output logic [31:0] bram_addr,
  output logic [31:0] bram_wdata,
  input  logic [31:0] bram_rdata,
  output logic        core_start,
  output logic        core_abort,
  output logic        core_gnt,
  input  logic        core_en,
  input  logic [3:0]  core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  input  logic        core_done,
  output logic        busy,
  output logic        err,
  output logic [15:0] job_count
);

  localparam int PW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [PW-1:0] POLL_RELOAD = PW'(POLL_INTERVAL - 1);
  localparam logic [WW-1:0] WDOG_LOAD   = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    POLL, CHECK, CLEAR, LAUNCH, RUN, FINISH, ABORT
  } state_t;

  state_t        state;
  logic [PW-1:0] poll_cnt;
  logic [WW-1:0] wdog;

  assign core_rdata = bram_rdata;

  // Control outputs are registered from the transition that enters their state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= POLL;
      poll_cnt   <= POLL_RELOAD;
      wdog       <= '0;
      core_start <= 1'b0;
      core_abort <= 1'b0;
      core_gnt   <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      job_count  <= '0;
    end else begin
      core_start <= 1'b0;
      core_abort <= 1'b0;
      case (state)
        POLL: begin
          if (poll_cnt == '0) state <= CHECK;
          else                poll_cnt <= poll_cnt - PW'(1);
        end
        CHECK: begin
          if (bram_rdata == START_MAGIC) begin
            state <= CLEAR;
          end else begin
            poll_cnt <= POLL_RELOAD;
            state    <= POLL;
          end
        end
        CLEAR: begin
          state      <= LAUNCH;
          core_start <= 1'b1;
          busy       <= 1'b1;
        end
        LAUNCH: begin
          state    <= RUN;
          wdog     <= WDOG_LOAD;
          core_gnt <= 1'b1;
        end
        RUN: begin
          wdog <= wdog - WW'(1);
          // A done arriving on the last watchdog cycle still counts as success.
          if (core_done) begin
            state    <= FINISH;
            core_gnt <= 1'b0;
          end else if (wdog == '0) begin
            state      <= ABORT;
            core_gnt   <= 1'b0;
            core_abort <= 1'b1;
          end
        end
        FINISH: begin
          job_count <= job_count + 16'd1;
          poll_cnt  <= POLL_RELOAD;
          busy      <= 1'b0;
          state     <= POLL;
        end
        ABORT: begin
          err      <= 1'b1;
          poll_cnt <= POLL_RELOAD;
          busy     <= 1'b0;
          state    <= POLL;
        end
        default: state <= POLL;
      endcase
    end
  end

  // Port mux: the core only reaches the BRAM while it holds the grant in RUN.
  always_comb begin
    bram_en    = 1'b0;
    bram_we    = 4'h0;
    bram_addr  = 32'h0;
    bram_wdata = 32'h0;
    case (state)
      POLL: begin
        if (poll_cnt == '0) begin
          bram_en   = 1'b1;
          bram_addr = START_ADDR;
        end
      end
      CLEAR: begin
        bram_en    = 1'b1;
        bram_we    = 4'hF;
        bram_addr  = START_ADDR;
        bram_wdata = CLEAR_WORD;
      end
      RUN: begin
        bram_en    = core_en;
        bram_we    = core_we;
        bram_addr  = core_addr;
        bram_wdata = core_wdata;
      end
      FINISH: begin
        bram_en    = 1'b1;
        bram_we    = 4'hF;
        bram_addr  = DONE_ADDR;
        bram_wdata = DONE_MAGIC;
      end
      ABORT: begin
        bram_en    = 1'b1;
        bram_we    = 4'hF;
        bram_addr  = DONE_ADDR;
        bram_wdata = ERR_MAGIC;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_acap_mailbox_ctrl.sv
// Directed bench for acap_mailbox_ctrl: a small BRAM model plus table vectors and
// hand-written sequences for polling, launch, pass-through, done/abort and reset.
module tb_acap_mailbox_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        bram_en;
  logic [3:0]  bram_we;
  logic [31:0] bram_addr;
  logic [31:0] bram_wdata;
  logic [31:0] bram_rdata = 32'h0;
  logic        core_start;
  logic        core_abort;
  logic        core_gnt;
  logic        core_en;
  logic [3:0]  core_we;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [31:0] core_rdata;
  logic        core_done;
  logic        busy;
  logic        err;
  logic [15:0] job_count;

  int errors = 0;
  int checks = 0;

  // BRAM model, host back-door and event counters
  logic [31:0] mem [0:8191];
  logic        host_we = 1'b0;
  logic [12:0] host_addr = 13'h0;
  logic [31:0] host_data = 32'h0;
  int wr_total = 0;
  int wr_start = 0;
  int start_pulses = 0;
  int abort_pulses = 0;

  acap_mailbox_ctrl #(.TIMEOUT(50)) dut (
    .clk(clk), .reset(reset),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .bram_rdata(bram_rdata),
    .core_start(core_start), .core_abort(core_abort), .core_gnt(core_gnt),
    .core_en(core_en), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_done(core_done),
    .busy(busy), .err(err), .job_count(job_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bram_en) begin
      bram_rdata <= mem[bram_addr[12:0]];
      for (int b = 0; b < 4; b++)
        if (bram_we[b]) mem[bram_addr[12:0]][8*b +: 8] <= bram_wdata[8*b +: 8];
      if (bram_we != 4'h0) begin
        wr_total <= wr_total + 1;
        if (bram_addr == 32'h1004) wr_start <= wr_start + 1;
      end
    end
    if (host_we) mem[host_addr] <= host_data;
    if (core_start) start_pulses <= start_pulses + 1;
    if (core_abort) abort_pulses <= abort_pulses + 1;
  end

  typedef struct {
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_en;
    logic [3:0]  exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic        chk_rd;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic [3:0] we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic done);
    core_en    = en;
    core_we    = we;
    core_addr  = addr;
    core_wdata = wdata;
    core_done  = done;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'h0);
    checkOutput({tag, "_err"}, 32'(err), 32'h0);
    checkOutput({tag, "_jobs"}, 32'(job_count), 32'h0);
    checkOutput({tag, "_start"}, 32'(core_start), 32'h0);
    checkOutput({tag, "_abort"}, 32'(core_abort), 32'h0);
    checkOutput({tag, "_gnt"}, 32'(core_gnt), 32'h0);
    checkOutput({tag, "_en"}, 32'(bram_en), 32'h0);
    checkOutput({tag, "_we"}, 32'(bram_we), 32'h0);
    checkOutput({tag, "_addr"}, bram_addr, 32'h0);
    checkOutput({tag, "_wdata"}, bram_wdata, 32'h0);
  endtask

  task automatic hostWrite(input logic [12:0] addr, input logic [31:0] data);
    host_addr = addr;
    host_data = data;
    host_we   = 1'b1;
    step();
    host_we   = 1'b0;
  endtask

  task automatic waitStart(input string tag);
    int k;
    k = 0;
    while (core_start !== 1'b1 && k < 60) begin
      step();
      k++;
    end
    checkOutput({tag, "_start_seen"}, 32'(core_start), 32'h1);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    int k;
    vecs[0] = '{1'b1, 4'hF, 32'h1800, 32'h11223344, 1'b1, 4'hF, 32'h1800, 32'h11223344, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 4'h3, 32'h1800, 32'hAAAA5566, 1'b1, 4'h3, 32'h1800, 32'hAAAA5566, 1'b0, 32'h0};
    vecs[2] = '{1'b1, 4'h0, 32'h1800, 32'h0,        1'b1, 4'h0, 32'h1800, 32'h0,        1'b0, 32'h0};
    vecs[3] = '{1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 4'h0, 32'h0,    32'h0,        1'b1, 32'h11225566};
    vecs[4] = '{1'b1, 4'hF, 32'h1FFF, 32'hCAFEF00D, 1'b1, 4'hF, 32'h1FFF, 32'hCAFEF00D, 1'b0, 32'h0};
    vecs[5] = '{1'b1, 4'h0, 32'h1FFF, 32'h0,        1'b1, 4'h0, 32'h1FFF, 32'h0,        1'b0, 32'h0};
    vecs[6] = '{1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 4'h0, 32'h0,    32'h0,        1'b1, 32'hCAFEF00D};

    applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    reset = 1'b1;
    step();
    hostWrite(13'h1004, 32'hDEADBE3F);
    hostWrite(13'h1789, 32'h0);
    checkIdle("reset");

    // Non-magic start word: reads every 17 cycles, no writes, no launch
    $display("[TB] polling with non-magic start word");
    reset = 1'b0;
    for (int n = 0; n < 53; n++) begin
      logic exp_rd;
      exp_rd = (n == 15 || n == 32 || n == 49);
      checkOutput($sformatf("poll_en_c%0d", n), 32'(bram_en), 32'(exp_rd));
      if (exp_rd) begin
        checkOutput("poll_addr", bram_addr, 32'h1004);
        checkOutput("poll_we", 32'(bram_we), 32'h0);
      end
      step();
    end
    checkOutput("poll_no_writes", 32'(wr_total), 32'h0);
    checkOutput("poll_no_start", 32'(start_pulses), 32'h0);

    // Magic start word: clear, launch, run
    $display("[TB] launching job 1");
    hostWrite(13'h1004, 32'hDEADBEEF);
    k = 0;
    while (!(bram_en && bram_we == 4'hF) && k < 40) begin
      step();
      k++;
    end
    checkOutput("clear_latency", 32'(k), 32'd14);
    checkOutput("clear_addr", bram_addr, 32'h1004);
    checkOutput("clear_wdata", bram_wdata, 32'h0);
    checkOutput("clear_no_start", 32'(core_start), 32'h0);
    step();
    checkOutput("launch_start", 32'(core_start), 32'h1);
    checkOutput("launch_busy", 32'(busy), 32'h1);
    checkOutput("launch_en", 32'(bram_en), 32'h0);
    checkOutput("launch_gnt", 32'(core_gnt), 32'h0);
    step();
    checkOutput("run_start_low", 32'(core_start), 32'h0);
    checkOutput("run_gnt", 32'(core_gnt), 32'h1);
    checkOutput("start_word_cleared", mem[13'h1004], 32'h0);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].wdata, 1'b0);
      #1;
      checkOutput($sformatf("vec%0d_en", i), 32'(bram_en), 32'(vecs[i].exp_en));
      checkOutput($sformatf("vec%0d_we", i), 32'(bram_we), 32'(vecs[i].exp_we));
      checkOutput($sformatf("vec%0d_addr", i), bram_addr, vecs[i].exp_addr);
      checkOutput($sformatf("vec%0d_wdata", i), bram_wdata, vecs[i].exp_wdata);
      if (vecs[i].chk_rd)
        checkOutput($sformatf("vec%0d_rdata", i), core_rdata, vecs[i].exp_rdata);
      step();
    end

    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 4'hF, 32'h1800 + 32'(i), 32'hA5000000 | 32'(i), 1'b0);
      step();
    end
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) applyStimulus(1'b1, 4'h0, 32'h1800 + 32'(i), 32'h0, 1'b0);
      else        applyStimulus(1'b1, 4'hF, 32'h1810, 32'h0D0E0F10, 1'b1);
      #1;
      if (i > 0)
        checkOutput($sformatf("readback_%0d", i - 1), core_rdata, 32'hA5000000 | 32'(i - 1));
      step();
    end
    applyStimulus(1'b1, 4'hF, 32'h1900, 32'h77777777, 1'b0);
    #1;
    checkOutput("finish_gnt", 32'(core_gnt), 32'h0);
    checkOutput("finish_addr", bram_addr, 32'h1789);
    checkOutput("finish_wdata", bram_wdata, 32'hD01ECAFE);
    checkOutput("finish_busy", 32'(busy), 32'h1);
    step();
    applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    checkOutput("job1_busy", 32'(busy), 32'h0);
    checkOutput("job1_count", 32'(job_count), 32'h1);
    checkOutput("job1_marker", mem[13'h1789], 32'hD01ECAFE);
    checkOutput("done_cycle_write", mem[13'h1810], 32'h0D0E0F10);
    checkOutput("mem_1800", mem[13'h1800], 32'hA5000000);
    checkOutput("mem_1fff", mem[13'h1FFF], 32'hCAFEF00D);
    checkOutput("single_clear", 32'(wr_start), 32'h1);

    // core_done and core traffic outside RUN are ignored
    applyStimulus(1'b1, 4'hF, 32'h1900, 32'h55555555, 1'b1);
    #1;
    checkOutput("poll_block_en", 32'(bram_en), 32'h0);
    step();
    applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    step();
    checkOutput("stray_done_busy", 32'(busy), 32'h0);
    checkOutput("stray_done_jobs", 32'(job_count), 32'h1);

    // Done on the final watchdog cycle wins over abort
    $display("[TB] done coinciding with watchdog expiry");
    hostWrite(13'h1004, 32'hDEADBEEF);
    waitStart("job2");
    for (int r = 1; r <= 50; r++) step();
    applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    checkOutput("last_cycle_gnt", 32'(core_gnt), 32'h1);
    step();
    applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    checkOutput("coinc_wdata", bram_wdata, 32'hD01ECAFE);
    checkOutput("coinc_no_abort", 32'(core_abort), 32'h0);
    step();
    checkOutput("coinc_err", 32'(err), 32'h0);
    checkOutput("coinc_jobs", 32'(job_count), 32'h2);
    checkOutput("coinc_marker", mem[13'h1789], 32'hD01ECAFE);

    // Core never finishes: abort 51 cycles after LAUNCH
    $display("[TB] watchdog abort");
    hostWrite(13'h1004, 32'hDEADBEEF);
    waitStart("job3");
    k = 0;
    while (core_abort !== 1'b1 && k < 100) begin
      step();
      k++;
    end
    checkOutput("abort_latency", 32'(k), 32'd51);
    checkOutput("abort_addr", bram_addr, 32'h1789);
    checkOutput("abort_wdata", bram_wdata, 32'hBADC0DE5);
    step();
    checkOutput("abort_pulse_low", 32'(core_abort), 32'h0);
    checkOutput("abort_err", 32'(err), 32'h1);
    checkOutput("abort_busy", 32'(busy), 32'h0);
    checkOutput("abort_marker", mem[13'h1789], 32'hBADC0DE5);
    checkOutput("abort_pulses", 32'(abort_pulses), 32'h1);

    // Another job after abort, then reset mid-RUN
    $display("[TB] reset during RUN");
    hostWrite(13'h1004, 32'hDEADBEEF);
    waitStart("job4");
    step();
    checkOutput("job4_gnt", 32'(core_gnt), 32'h1);
    checkOutput("job4_err_sticky", 32'(err), 32'h1);
    applyStimulus(1'b1, 4'hF, 32'h1900, 32'h12345678, 1'b0);
    #1;
    checkOutput("job4_pass_addr", bram_addr, 32'h1900);
    reset = 1'b1;
    step();
    checkIdle("midrun");
    reset = 1'b0;
    applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    step();
    checkOutput("midrun_marker", mem[13'h1789], 32'hBADC0DE5);

    hostWrite(13'h1004, 32'hDEADBEEF);
    waitStart("job5");
    step();
    applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    step();
    applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    step();
    checkOutput("job5_jobs", 32'(job_count), 32'h1);
    checkOutput("job5_err", 32'(err), 32'h0);
    checkOutput("job5_marker", mem[13'h1789], 32'hD01ECAFE);
    checkOutput("total_starts", 32'(start_pulses), 32'd5);
    checkOutput("total_clears", 32'(wr_start), 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
